io_buttons: RTL and testbench



---
 rtl/io_buttons.sv | 162 ++++++++++++++++
 tb/tb_io_buttons.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_buttons.sv
// io_buttons: debounced push-button slave on the I/O bus.
// Raw buttons are synchronized and debounced. Press events are latched in
// sticky bits, counted in an 8-bit counter and masked onto a level interrupt.
// A three-state handshake FSM (IDLE/ACK/RELEASE) gives exactly one ready
// pulse per request.
module io_buttons #(
  parameter int N_BUTTONS       = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BUTTONS-1:0]  buttons,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  read,
  input  logic                  write,
  output logic                  ready,
  output logic                  irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value at which one more mismatching cycle accepts the new level.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_REL} state_t;

  logic [N_BUTTONS-1:0]         sync1_q, sync2_q;
  logic [N_BUTTONS-1:0]         stable_q, stable_d;
  logic [N_BUTTONS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_BUTTONS-1:0]         rise;
  logic [N_BUTTONS-1:0]         event_q, event_d, ev_clr;
  logic [N_BUTTONS-1:0]         irq_en_q;
  logic [7:0]                   count_q, count_d, inc;
  logic                         cnt_clr, en_wr, wr_ack;

  state_t                       state_q;
  logic [ADDR_WIDTH-1:0]        cap_addr_q;
  logic [N_BUTTONS-1:0]         cap_wdata_q;
  logic                         cap_wr_q;
  logic                         ready_q, irq_q;
  logic [DATA_WIDTH-1:0]        rdata_q, rd_val;

  // Only the low N_BUTTONS bits of wdata carry information for any register.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise = stable_d & ~stable_q;

  // Number of buttons whose debounced level rises this cycle.
  always_comb begin
    inc = '0;
    for (int i = 0; i < N_BUTTONS; i++) inc = inc + 8'(rise[i]);
  end

  // Bus writes land at the end of the ACK cycle; a new press beats a clear.
  always_comb begin
    wr_ack  = (state_q == S_ACK) && cap_wr_q;
    ev_clr  = (wr_ack && cap_addr_q == ADDR_WIDTH'(1)) ? cap_wdata_q : '0;
    cnt_clr = wr_ack && (cap_addr_q == ADDR_WIDTH'(2));
    en_wr   = wr_ack && (cap_addr_q == ADDR_WIDTH'(3));
    event_d = (event_q & ~ev_clr) | rise;
    count_d = (cnt_clr ? 8'd0 : count_q) + inc;
  end

  // Register read mux, sampled into rdata_q when a request is captured.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_WIDTH'(0): rd_val[N_BUTTONS-1:0] = stable_q;
      ADDR_WIDTH'(1): rd_val[N_BUTTONS-1:0] = event_q;
      ADDR_WIDTH'(2): rd_val[7:0]           = count_q;
      ADDR_WIDTH'(3): rd_val[N_BUTTONS-1:0] = irq_en_q;
      default:        rd_val                = '0;
    endcase
  end

  // Synchronizer, debounce state and the software-visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      event_q  <= '0;
      count_q  <= '0;
      irq_en_q <= '0;
    end else begin
      sync1_q  <= buttons;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
      count_q  <= count_d;
      if (en_wr) irq_en_q <= cap_wdata_q;
    end
  end

  // Interrupt level is registered from the current event and mask registers.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |(event_q & irq_en_q);
  end

  // Handshake FSM: capture, one-cycle ack, then wait for the request to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_wr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (read || write) begin
            cap_addr_q  <= addr;
            cap_wdata_q <= wdata[N_BUTTONS-1:0];
            cap_wr_q    <= write;
            rdata_q     <= write ? '0 : rd_val;
            ready_q     <= 1'b1;
            state_q     <= S_ACK;
          end
        end
        S_ACK: begin
          ready_q <= 1'b0;
          rdata_q <= '0;
          state_q <= S_REL;
        end
        S_REL: begin
          if (!read && !write) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_io_buttons.sv
// Bench for io_buttons with a short debounce window. A spec-level model runs
// alongside the DUT; directed sequences cover the timing corners.
module tb_io_buttons;

  localparam int NB = 8;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  buttons = '0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        read = 1'b0, write = 1'b0;
  logic        ready, irq;

  io_buttons #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .addr(addr), .wdata(wdata),
    .rdata(rdata), .read(read), .write(write), .ready(ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [7:0]  m_s1 = '0, m_s2 = '0, m_st = '0, m_ev = '0, m_en = '0, m_cnt = '0;
  logic        m_irq = 1'b0;
  int          m_run [NB];
  logic [7:0]  m_rise, m_clr;
  logic        m_cclr;
  int          wr_seq = 0, wr_done = 0;
  logic [3:0]  m_pa = '0;
  logic [31:0] m_pd = '0;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0: return {24'd0, m_st};
      4'd1: return {24'd0, m_ev};
      4'd2: return {24'd0, m_cnt};
      4'd3: return {24'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Model: a button's accepted level flips once the synchronized input has
  // disagreed with it for DB cycles in a row; rises are events and count.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_ev = '0; m_en = '0; m_cnt = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      wr_done = wr_seq;
    end else begin
      m_irq  = |(m_ev & m_en);
      m_rise = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_st[i] = m_s2[i];
            m_run[i] = 0;
            m_rise[i] = m_st[i];
          end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = buttons;
      m_clr = '0;
      m_cclr = 1'b0;
      if (wr_done != wr_seq) begin
        if (m_pa == 4'd1) m_clr = m_pd[7:0];
        if (m_pa == 4'd2) m_cclr = 1'b1;
        if (m_pa == 4'd3) m_en = m_pd[7:0];
        wr_done = wr_seq;
      end
      m_ev  = (m_ev & ~m_clr) | m_rise;
      m_cnt = (m_cclr ? 8'd0 : m_cnt) + 8'($countones(m_rise));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One negedge; irq is compared with the model every cycle.
  task automatic tick();
    @(negedge clk);
    if (chk_en) chk("irq_model", 32'(irq), 32'(m_irq));
  endtask

  task automatic waitn(input int n);
    repeat (n) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1; read = 1'b0; write = 1'b0; buttons = '0;
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  // Full bus transaction started at a negedge: ack must appear exactly one
  // cycle later and only once. exp is the model value at capture time.
  task automatic bus(input bit wr, input bit both, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic [31:0] exp);
    exp = wr ? 32'd0 : m_read(a);
    addr = a; wdata = d; write = wr; read = !wr || both;
    tick();
    chk("bus_ack", 32'(ready), 32'd1);
    rd = rdata;
    if (wr) begin m_pa = a; m_pd = d; wr_seq++; end
    read = 1'b0; write = 1'b0;
    tick();
    chk("bus_ack_once", 32'(ready), 32'd0);
    tick();
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] req);
    logic [31:0] rd, ex;
    bus(1'b0, 1'b0, a, 32'd0, rd, ex);
    chk(nm, rd, req);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd, ex;
    bus(1'b1, 1'b0, a, d, rd, ex);
  endtask

  typedef struct {
    bit          wr;
    bit          both;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [14];
  logic [3:0]  alist [5];
  logic [31:0] rd, ex;
  int          pulses, pidx, r;
  logic [31:0] prd;

  initial begin
    tbl[0]  = '{0, 0, 4'd0, 32'h0,         32'h0};
    tbl[1]  = '{0, 0, 4'd1, 32'h0,         32'h0};
    tbl[2]  = '{0, 0, 4'd2, 32'h0,         32'h0};
    tbl[3]  = '{0, 0, 4'd3, 32'h0,         32'h0};
    tbl[4]  = '{1, 0, 4'd3, 32'h0000_00A5, 32'h0};
    tbl[5]  = '{0, 0, 4'd3, 32'h0,         32'h0000_00A5};
    tbl[6]  = '{1, 0, 4'd3, 32'hFFFF_FF3C, 32'h0};
    tbl[7]  = '{0, 0, 4'd3, 32'h0,         32'h0000_003C};
    tbl[8]  = '{1, 0, 4'd0, 32'h0000_00FF, 32'h0};
    tbl[9]  = '{0, 0, 4'd0, 32'h0,         32'h0};
    tbl[10] = '{0, 0, 4'd9, 32'h0,         32'h0};
    tbl[11] = '{1, 0, 4'd9, 32'h1234_5678, 32'h0};
    tbl[12] = '{1, 1, 4'd3, 32'h0000_000F, 32'h0};
    tbl[13] = '{0, 0, 4'd3, 32'h0,         32'h0000_000F};
    alist = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9};

    // Clean press: STATE still 0 five cycles in, 1 after six.
    reset_dut();
    buttons = 8'h01;
    waitn(5);
    rd_chk("press_state_early", 4'd0, 32'h00);
    reset_dut();
    buttons = 8'h01;
    waitn(6);
    rd_chk("press_state_6", 4'd0, 32'h01);
    rd_chk("press_event", 4'd1, 32'h01);
    rd_chk("press_count", 4'd2, 32'h01);
    chk("press_irq_masked", 32'(irq), 32'd0);

    // Bounce on button 2, then a clean hold.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      buttons = (k % 2 == 0) ? 8'h04 : 8'h00;
      waitn(2);
    end
    buttons = 8'h04;
    waitn(2);
    rd_chk("bounce_no_early", 4'd0, 32'h00);
    waitn(10);
    rd_chk("bounce_event", 4'd1, 32'h04);
    rd_chk("bounce_count", 4'd2, 32'h01);

    // Counter wrap: 254 presses, then four simultaneous rises.
    reset_dut();
    for (int k = 0; k < 32; k++) begin
      buttons = (k == 31) ? 8'h3F : 8'hFF;
      waitn(8);
      buttons = 8'h00;
      waitn(8);
    end
    rd_chk("count_254", 4'd2, 32'hFE);
    wr_reg(4'd1, 32'hFF);
    buttons = 8'h0F;
    waitn(8);
    rd_chk("count_wrap", 4'd2, 32'h02);
    rd_chk("event_0f", 4'd1, 32'h0F);

    // IRQ raise, clear, and a press landing on the clearing edge.
    reset_dut();
    wr_reg(4'd3, 32'h01);
    buttons = 8'h01;
    waitn(8);
    chk("irq_set", 32'(irq), 32'd1);
    buttons = 8'h00;
    waitn(8);
    wr_reg(4'd1, 32'h01);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("event_cleared", 4'd1, 32'h00);
    buttons = 8'h01;
    waitn(4);
    wr_reg(4'd1, 32'h01);
    rd_chk("set_wins_clear", 4'd1, 32'h01);
    chk("irq_after_race", 32'(irq), 32'd1);

    // Held read: one ack, one cycle after the request, carrying STATE.
    addr = 4'd0; read = 1'b1;
    pulses = 0; pidx = -1; prd = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ready) begin pulses++; if (pidx < 0) begin pidx = k; prd = rdata; end end
    end
    read = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd1);
    chk("hold_pulse_idx", 32'(pidx), 32'd0);
    chk("hold_rdata", prd, 32'h01);
    waitn(2);

    // Reset during ACK and during a debounce count.
    reset_dut();
    wr_reg(4'd3, 32'h03);
    buttons = 8'h01;
    waitn(8);
    chk("mid_irq_before", 32'(irq), 32'd1);
    buttons = 8'h03;
    waitn(3);
    addr = 4'd0; read = 1'b1;
    tick();
    chk("mid_ack", 32'(ready), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    pulses = 0; prd = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ready) begin pulses++; prd = rdata; end
    end
    read = 1'b0;
    chk("mid_reack_once", 32'(pulses), 32'd1);
    chk("mid_state_zero", prd, 32'h00);
    waitn(12);
    rd_chk("mid_recount", 4'd2, 32'h02);
    rd_chk("mid_reevent", 4'd1, 32'h03);

    // Register table.
    reset_dut();
    for (int k = 0; k < 14; k++) begin
      bus(tbl[k].wr, tbl[k].both, tbl[k].a, tbl[k].d, rd, ex);
      if (!tbl[k].wr) chk($sformatf("tbl_%0d", k), rd, tbl[k].exp);
    end

    // Random buttons and bus traffic against the model.
    reset_dut();
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        buttons = buttons ^ 8'(1 << $urandom_range(0, 7));
        waitn($urandom_range(1, 9));
      end else if (r < 8) begin
        bus(1'b0, 1'b0, alist[$urandom_range(0, 4)], 32'd0, rd, ex);
        chk("rnd_read", rd, ex);
      end else begin
        bus(1'b1, 1'b0, 4'($urandom_range(1, 3)), $urandom, rd, ex);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
